armleocpu_decode: RTL and testbench

Decode stage between fetch and execute. It accepts fetched instructions and fetch-raised exceptions, cracks each instruction into an opcode class, register indices and a sign-extended immediate, and presents one registered bundle per cycle to execute over a valid/ready handshake. A two-entry buffer (main and skid) decouples fetch timing from execute back-pressure. It kills in-flight instructions on an execute redirect.

---
 rtl/armleocpu_decode.sv | 187 ++++++++++++++++++
 tb/tb_armleocpu_decode.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_decode.sv
// rtl/armleocpu_decode.sv - decode stage with main/skid buffer between fetch and execute
module armleocpu_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f2d_instr_valid,
    input  logic [31:0] f2d_instr,
    input  logic [31:0] f2d_pc,
    input  logic        f2d_exc_start,
    input  logic [31:0] f2d_epc,
    input  logic [31:0] f2d_cause,
    input  logic [1:0]  f2d_exc_privilege,
    output logic        d2f_ready,
    output logic        d2e_valid,
    output logic [31:0] d2e_instr,
    output logic [31:0] d2e_pc,
    output logic [3:0]  d2e_class,
    output logic [4:0]  d2e_rd,
    output logic [4:0]  d2e_rs1,
    output logic [4:0]  d2e_rs2,
    output logic [31:0] d2e_imm,
    output logic        d2e_illegal,
    output logic        d2e_exc_start,
    output logic [31:0] d2e_epc,
    output logic [31:0] d2e_cause,
    output logic [1:0]  d2e_exc_privilege,
    input  logic        e2d_ready,
    input  logic        e2d_flush
);

    localparam logic [3:0] CLS_LUI      = 4'd0;
    localparam logic [3:0] CLS_AUIPC    = 4'd1;
    localparam logic [3:0] CLS_JAL      = 4'd2;
    localparam logic [3:0] CLS_JALR     = 4'd3;
    localparam logic [3:0] CLS_BRANCH   = 4'd4;
    localparam logic [3:0] CLS_LOAD     = 4'd5;
    localparam logic [3:0] CLS_STORE    = 4'd6;
    localparam logic [3:0] CLS_OP_IMM   = 4'd7;
    localparam logic [3:0] CLS_OP       = 4'd8;
    localparam logic [3:0] CLS_MISC_MEM = 4'd9;
    localparam logic [3:0] CLS_SYSTEM   = 4'd10;
    localparam logic [3:0] CLS_ILLEGAL  = 4'd15;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic        exc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic [1:0]  priv;
    } bundle_t;

    bundle_t main_q, skid_q, main_n, skid_n, dec, new_entry;
    logic    main_valid, skid_valid, main_valid_n, skid_valid_n;
    logic    ready_q;
    logic    new_valid, drain, main_keep, skid_keep;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // Crack the incoming fetch word into class, register indices and immediate
    always_comb begin
        imm_i = {{20{f2d_instr[31]}}, f2d_instr[31:20]};
        imm_s = {{20{f2d_instr[31]}}, f2d_instr[31:25], f2d_instr[11:7]};
        imm_b = {{19{f2d_instr[31]}}, f2d_instr[31], f2d_instr[7],
                 f2d_instr[30:25], f2d_instr[11:8], 1'b0};
        imm_u = {f2d_instr[31:12], 12'b0};
        imm_j = {{11{f2d_instr[31]}}, f2d_instr[31], f2d_instr[19:12],
                 f2d_instr[20], f2d_instr[30:21], 1'b0};

        dec       = '0;
        dec.instr = f2d_instr;
        dec.pc    = f2d_pc;
        dec.rd    = f2d_instr[11:7];
        dec.rs1   = f2d_instr[19:15];
        dec.rs2   = f2d_instr[24:20];
        dec.cls   = CLS_ILLEGAL;
        if (f2d_instr[1:0] == 2'b11) begin
            case (f2d_instr[6:2])
                5'b01101: dec.cls = CLS_LUI;
                5'b00101: dec.cls = CLS_AUIPC;
                5'b11011: dec.cls = CLS_JAL;
                5'b11001: dec.cls = CLS_JALR;
                5'b11000: dec.cls = CLS_BRANCH;
                5'b00000: dec.cls = CLS_LOAD;
                5'b01000: dec.cls = CLS_STORE;
                5'b00100: dec.cls = CLS_OP_IMM;
                5'b01100: dec.cls = CLS_OP;
                5'b00011: dec.cls = CLS_MISC_MEM;
                5'b11100: dec.cls = CLS_SYSTEM;
                default:  dec.cls = CLS_ILLEGAL;
            endcase
        end
        dec.illegal = (dec.cls == CLS_ILLEGAL);
        case (dec.cls)
            CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_SYSTEM: dec.imm = imm_i;
            CLS_STORE:                                  dec.imm = imm_s;
            CLS_BRANCH:                                 dec.imm = imm_b;
            CLS_LUI, CLS_AUIPC:                         dec.imm = imm_u;
            CLS_JAL:                                    dec.imm = imm_j;
            default:                                    dec.imm = '0;
        endcase
    end

    // Select what a newly accepted entry looks like; an exception wins over an instruction
    always_comb begin
        new_entry = dec;
        if (f2d_exc_start) begin
            new_entry       = '0;
            new_entry.exc   = 1'b1;
            new_entry.epc   = f2d_epc;
            new_entry.cause = f2d_cause;
            new_entry.priv  = f2d_exc_privilege;
        end
        new_valid = f2d_exc_start ||
                    (f2d_instr_valid && ready_q && !e2d_flush);
        drain     = main_valid && e2d_ready;
        main_keep = main_valid && !drain && (!e2d_flush || main_q.exc);
        skid_keep = skid_valid && (!e2d_flush || skid_q.exc);
    end

    // Compact surviving entries in order (main, skid, new) into the two slots
    always_comb begin
        main_valid_n = 1'b0;
        skid_valid_n = 1'b0;
        main_n       = '0;
        skid_n       = '0;
        if (main_keep) begin
            main_valid_n = 1'b1;
            main_n       = main_q;
            if (skid_keep) begin
                skid_valid_n = 1'b1;
                skid_n       = skid_q;
            end else if (new_valid) begin
                skid_valid_n = 1'b1;
                skid_n       = new_entry;
            end
        end else if (skid_keep) begin
            main_valid_n = 1'b1;
            main_n       = skid_q;
            if (new_valid) begin
                skid_valid_n = 1'b1;
                skid_n       = new_entry;
            end
        end else if (new_valid) begin
            main_valid_n = 1'b1;
            main_n       = new_entry;
        end
    end

    // Slot registers and the registered ready toward fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            ready_q    <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            ready_q    <= !skid_valid_n;
        end
    end

    assign d2f_ready         = ready_q;
    assign d2e_valid         = main_valid;
    assign d2e_instr         = main_q.instr;
    assign d2e_pc            = main_q.pc;
    assign d2e_class         = main_q.cls;
    assign d2e_rd            = main_q.rd;
    assign d2e_rs1           = main_q.rs1;
    assign d2e_rs2           = main_q.rs2;
    assign d2e_imm           = main_q.imm;
    assign d2e_illegal       = main_q.illegal;
    assign d2e_exc_start     = main_q.exc;
    assign d2e_epc           = main_q.epc;
    assign d2e_cause         = main_q.cause;
    assign d2e_exc_privilege = main_q.priv;

endmodule

// File: tb/tb_armleocpu_decode.sv
// tb/tb_armleocpu_decode.sv - directed self-checking bench for armleocpu_decode
module tb_armleocpu_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f2d_instr_valid;
    logic [31:0] f2d_instr;
    logic [31:0] f2d_pc;
    logic        f2d_exc_start;
    logic [31:0] f2d_epc;
    logic [31:0] f2d_cause;
    logic [1:0]  f2d_exc_privilege;
    logic        d2f_ready;
    logic        d2e_valid;
    logic [31:0] d2e_instr;
    logic [31:0] d2e_pc;
    logic [3:0]  d2e_class;
    logic [4:0]  d2e_rd;
    logic [4:0]  d2e_rs1;
    logic [4:0]  d2e_rs2;
    logic [31:0] d2e_imm;
    logic        d2e_illegal;
    logic        d2e_exc_start;
    logic [31:0] d2e_epc;
    logic [31:0] d2e_cause;
    logic [1:0]  d2e_exc_privilege;
    logic        e2d_ready;
    logic        e2d_flush;

    int errors = 0;
    int checks = 0;
    logic started = 1'b0;

    armleocpu_decode dut (
        .clk(clk), .rst_n(rst_n),
        .f2d_instr_valid(f2d_instr_valid), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc),
        .f2d_exc_start(f2d_exc_start), .f2d_epc(f2d_epc), .f2d_cause(f2d_cause),
        .f2d_exc_privilege(f2d_exc_privilege),
        .d2f_ready(d2f_ready), .d2e_valid(d2e_valid), .d2e_instr(d2e_instr),
        .d2e_pc(d2e_pc), .d2e_class(d2e_class), .d2e_rd(d2e_rd), .d2e_rs1(d2e_rs1),
        .d2e_rs2(d2e_rs2), .d2e_imm(d2e_imm), .d2e_illegal(d2e_illegal),
        .d2e_exc_start(d2e_exc_start), .d2e_epc(d2e_epc), .d2e_cause(d2e_cause),
        .d2e_exc_privilege(d2e_exc_privilege),
        .e2d_ready(e2d_ready), .e2d_flush(e2d_flush)
    );

    always #5 clk = ~clk;

    // Fetch must not raise an exception while the skid slot is occupied
    always @(posedge clk) begin
        if (started && rst_n)
            assert (!(f2d_exc_start && !d2f_ready))
                else $error("exception raised while skid full");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f2d_instr_valid   = 1'b0;
        f2d_instr         = '0;
        f2d_pc            = '0;
        f2d_exc_start     = 1'b0;
        f2d_epc           = '0;
        f2d_cause         = '0;
        f2d_exc_privilege = '0;
        e2d_flush         = 1'b0;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        f2d_instr_valid = 1'b1;
        f2d_instr       = ins;
        f2d_pc          = pc;
    endtask

    initial begin
        idle_inputs();
        e2d_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        started = 1'b1;

        // Reset state
        check("rst_valid", {31'b0, d2e_valid}, 32'd0);
        check("rst_ready", {31'b0, d2f_ready}, 32'd1);
        check("rst_instr", d2e_instr, 32'd0);
        check("rst_exc",   {31'b0, d2e_exc_start}, 32'd0);

        // Stream: ADDI then ADD with execute always ready
        send(32'h00500093, 32'h2000);
        tick();
        check("addi_valid", {31'b0, d2e_valid}, 32'd1);
        check("addi_class", {28'b0, d2e_class}, 32'd7);
        check("addi_imm",   d2e_imm, 32'd5);
        check("addi_rd",    {27'b0, d2e_rd}, 32'd1);
        check("addi_rs1",   {27'b0, d2e_rs1}, 32'd0);
        check("addi_pc",    d2e_pc, 32'h2000);
        send(32'h00208133, 32'h2004);
        tick();
        check("add_class", {28'b0, d2e_class}, 32'd8);
        check("add_rd",    {27'b0, d2e_rd}, 32'd2);
        check("add_rs1",   {27'b0, d2e_rs1}, 32'd1);
        check("add_rs2",   {27'b0, d2e_rs2}, 32'd2);
        check("add_ready", {31'b0, d2f_ready}, 32'd1);
        idle_inputs();
        tick();
        check("stream_empty", {31'b0, d2e_valid}, 32'd0);

        // Back-pressure: three instructions while execute stalls
        e2d_ready = 1'b0;
        send(32'h00500093, 32'h3000);
        tick();
        check("bp1_ready", {31'b0, d2f_ready}, 32'd1);
        check("bp1_instr", d2e_instr, 32'h00500093);
        send(32'h00208133, 32'h3004);
        tick();
        check("bp2_ready", {31'b0, d2f_ready}, 32'd0);
        check("bp2_instr", d2e_instr, 32'h00500093);
        send(32'h123450B7, 32'h3008);
        tick();
        check("bp3_ready", {31'b0, d2f_ready}, 32'd0);
        check("bp3_stable", d2e_instr, 32'h00500093);
        e2d_ready = 1'b1;
        tick();
        check("bp_out2", d2e_instr, 32'h00208133);
        check("bp_out2_pc", d2e_pc, 32'h3004);
        check("bp_ready_back", {31'b0, d2f_ready}, 32'd1);
        tick();
        check("bp_out3", d2e_instr, 32'h123450B7);
        check("bp_out3_pc", d2e_pc, 32'h3008);
        idle_inputs();
        tick();
        check("bp_empty", {31'b0, d2e_valid}, 32'd0);

        // Immediate formats
        send(32'hFE000EE3, 32'h4000);
        tick();
        check("beq_class", {28'b0, d2e_class}, 32'd4);
        check("beq_imm", d2e_imm, 32'hFFFFFFFC);
        send(32'h0040006F, 32'h4004);
        tick();
        check("jal_class", {28'b0, d2e_class}, 32'd2);
        check("jal_imm", d2e_imm, 32'd4);
        send(32'h00112623, 32'h4008);
        tick();
        check("sw_class", {28'b0, d2e_class}, 32'd6);
        check("sw_imm", d2e_imm, 32'd12);
        send(32'h123450B7, 32'h400C);
        tick();
        check("lui_class", {28'b0, d2e_class}, 32'd0);
        check("lui_imm", d2e_imm, 32'h12345000);

        // Illegal encodings
        send(32'h00000000, 32'h5000);
        tick();
        check("ill0_class", {28'b0, d2e_class}, 32'd15);
        check("ill0_flag", {31'b0, d2e_illegal}, 32'd1);
        check("ill0_valid", {31'b0, d2e_valid}, 32'd1);
        send(32'h0000007F, 32'h5004);
        tick();
        check("ill7f_class", {28'b0, d2e_class}, 32'd15);
        check("ill7f_flag", {31'b0, d2e_illegal}, 32'd1);
        idle_inputs();
        tick();

        // Flush: instruction in main, exception in skid, instruction arriving
        e2d_ready = 1'b0;
        send(32'h00500093, 32'h6000);
        tick();
        idle_inputs();
        f2d_exc_start     = 1'b1;
        f2d_epc           = 32'h6004;
        f2d_cause         = 32'd1;
        f2d_exc_privilege = 2'd3;
        tick();
        idle_inputs();
        check("fl_pre_instr", d2e_instr, 32'h00500093);
        e2d_flush = 1'b1;
        send(32'h00208133, 32'h6008);
        tick();
        e2d_flush = 1'b0;
        idle_inputs();
        check("fl_valid", {31'b0, d2e_valid}, 32'd1);
        check("fl_exc", {31'b0, d2e_exc_start}, 32'd1);
        check("fl_epc", d2e_epc, 32'h6004);
        check("fl_cause", d2e_cause, 32'd1);
        check("fl_priv", {30'b0, d2e_exc_privilege}, 32'd3);
        check("fl_instr", d2e_instr, 32'd0);
        e2d_ready = 1'b1;
        tick();
        check("fl_dropped", {31'b0, d2e_valid}, 32'd0);

        // Exception and instruction in the same cycle
        send(32'h00500093, 32'h7000);
        f2d_exc_start = 1'b1;
        f2d_epc       = 32'h7000;
        f2d_cause     = 32'd5;
        tick();
        idle_inputs();
        check("both_exc", {31'b0, d2e_exc_start}, 32'd1);
        check("both_cause", d2e_cause, 32'd5);
        check("both_instr", d2e_instr, 32'd0);
        tick();
        check("both_only", {31'b0, d2e_valid}, 32'd0);

        // Reset mid-stream
        e2d_ready = 1'b0;
        send(32'h00500093, 32'h8000);
        tick();
        send(32'h00208133, 32'h8004);
        tick();
        check("mid_ready0", {31'b0, d2f_ready}, 32'd0);
        idle_inputs();
        rst_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'b0, d2e_valid}, 32'd0);
        check("mid_rst_ready", {31'b0, d2f_ready}, 32'd1);
        rst_n     = 1'b1;
        e2d_ready = 1'b1;
        tick();
        check("mid_rst_after", {31'b0, d2e_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
